// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial add/subtract datapath:
// FSM encoding and digit/counter sizing helpers.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int ndig(input int width, input int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder; chained DIGIT times to form the per-cycle ripple digit.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, carry held between digits,
// operands and result exchanged on valid/ready handshakes.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_width(NDIG);
    localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DSAFE) != 0)) begin : g_cfg_err
        $error("serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
    end

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] sum_shift;
    logic             last;

    assign c[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fa_cell u_fa (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (c[i]),
            .sum  (dsum[i]),
            .cout (c[i+1])
        );
    end

    // New digit enters at the top; after NDIG steps the result is aligned.
    if (DIGIT == WIDTH) begin : g_shift_full
        assign sum_shift = dsum;
    end else begin : g_shift_part
        assign sum_shift = {dsum, sum_q[WIDTH-1:DIGIT]};
    end

    assign last = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shift;
                carry_d = c[DIGIT];
                if (last) begin
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at DIGIT = 4, 16 and 1, checked against an
// arithmetic reference model.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  in_valid, out_ready;
    logic [2:0]  in_ready, out_valid, cout_o, ovf_o;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum_o [3];

    int checks = 0;
    int errors = 0;
    int lat_tab [3] = '{4, 1, 16};

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [15:0] a_, input logic [15:0] b_,
                         input logic c_, input logic s_,
                         output logic [15:0] es, output logic ec,
                         output logic eo);
        int full;
        int sa, sb, sv;
        sa = $signed(a_);
        sb = $signed(b_);
        if (!s_) begin
            full = int'(a_) + int'(b_) + int'(c_);
            sv   = sa + sb + int'(c_);
        end else begin
            full = int'(a_) + 65536 - int'(b_) - int'(c_);
            sv   = sa - sb - int'(c_);
        end
        es = full[15:0];
        ec = full[16];
        eo = (sv > 32767) || (sv < -32768);
    endtask

    task automatic run_op(input int idx, input logic [15:0] a_,
                          input logic [15:0] b_, input logic c_,
                          input logic s_, input int hold,
                          input string tag);
        logic [15:0] es;
        logic        ec, eo;
        int          lat;
        model(a_, b_, c_, s_, es, ec, eo);
        @(negedge clk);
        a = a_; b = b_; cin = c_; sub = s_;
        in_valid[idx] = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready[idx]), 32'd1);
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        chk({tag, "_busy"}, 32'(in_ready[idx]), 32'd0);
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 64) begin
            in_valid[idx] = 1'($urandom_range(0, 1));
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid[idx] = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(lat_tab[idx]));
        chk({tag, "_sum"}, 32'(sum_o[idx]), 32'(es));
        chk({tag, "_cout"}, 32'(cout_o[idx]), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf_o[idx]), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            in_valid[idx] = 1'($urandom_range(0, 1));
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold"},
                {12'd0, out_valid[idx], in_ready[idx], cout_o[idx],
                 ovf_o[idx], sum_o[idx]},
                {12'd0, 1'b1, 1'b0, ec, eo, es});
        end
        @(negedge clk);
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
        chk({tag, "_release"},
            {30'd0, out_valid[idx], in_ready[idx]}, 32'd1);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        in_valid = '0; out_ready = '0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_state",
                {12'd0, in_ready[k], out_valid[k], cout_o[k], ovf_o[k],
                 sum_o[k]},
                {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        end

        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, "add_basic");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_wrap");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "add_ovf");
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_borrow");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
        run_op(0, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, "sub_cin");
        run_op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 10, "hold10");

        // Reset while the first digits are being processed.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid",
            {14'd0, in_ready[0], out_valid[0], sum_o[0]},
            {14'd0, 1'b1, 1'b0, 16'h0000});
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | out_valid[0];
        end
        chk("rst_no_result", 32'(seen), 32'd0);
        run_op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 0, "post_rst");

        run_op(1, 16'hABCD, 16'h1111, 1'b1, 1'b0, 0, "d16_add");
        run_op(2, 16'hABCD, 16'h1111, 1'b1, 1'b0, 0, "d1_add");

        for (int n = 0; n < 40; n++) begin
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3), "rnd_d4");
        end
        for (int n = 0; n < 10; n++) begin
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 2), "rnd_d16");
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 2), "rnd_d1");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
